// File: rtl/out_queue_bank_pkg.sv
// Shared constants, header layout, packet-state encoding and the CRC-32 step for out_queue_bank.
package out_queue_bank_pkg;
  localparam int DATA_WIDTH       = 64;
  localparam int PORT_NUB_TOTAL   = 4;
  localparam int PRI_NUM_TOTAL    = 8;
  localparam int CRC32_LENGTH     = 32;
  localparam int DATABUF_HIGH_NUM = 8;

  localparam int PORT_WIDTH = $clog2(PORT_NUB_TOTAL);
  localparam int PRI_W      = $clog2(PRI_NUM_TOTAL);

  localparam logic [CRC32_LENGTH-1:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [CRC32_LENGTH-1:0] CRC32_INIT = 32'hFFFF_FFFF;

  // Header word: {zero pad, frame_num, crc, pri}, LSB-aligned
  localparam int HDR_PRI_LSB = 0;
  localparam int HDR_CRC_LSB = PRI_W;
  localparam int HDR_FRM_LSB = PRI_W + CRC32_LENGTH;

  typedef enum logic [1:0] {
    PKT_IDLE    = 2'd0,
    PKT_FILL    = 2'd1,
    PKT_DISCARD = 2'd2
  } pkt_state_e;

  // One data word folded in MSB first, no reflection, no final XOR
  function automatic logic [CRC32_LENGTH-1:0] crc32_next(
    input logic [CRC32_LENGTH-1:0] crc,
    input logic [DATA_WIDTH-1:0]   data
  );
    logic [CRC32_LENGTH-1:0] c;
    c = crc;
    for (int i = DATA_WIDTH - 1; i >= 0; i--)
      c = {c[CRC32_LENGTH-2:0], 1'b0} ^ ((c[CRC32_LENGTH-1] ^ data[i]) ? CRC32_POLY : '0);
    return c;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] make_header(
    input logic [DATABUF_HIGH_NUM-1:0] frame_num,
    input logic [CRC32_LENGTH-1:0]     crc,
    input logic [PRI_W-1:0]            pri
  );
    logic [DATA_WIDTH-1:0] h;
    h = '0;
    h[HDR_PRI_LSB +: PRI_W]            = pri;
    h[HDR_CRC_LSB +: CRC32_LENGTH]     = crc;
    h[HDR_FRM_LSB +: DATABUF_HIGH_NUM] = frame_num;
    return h;
  endfunction
endpackage

// File: rtl/out_queue_bank_port_queue.sv
// One circular packet queue: header slot reserved at sop, written at eop, commit on eop, rewind on drop.
module port_queue
  import out_queue_bank_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_vld,
  input  logic                  wr_sop,
  input  logic                  wr_eop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [PRI_W-1:0]      wr_pri,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_USED = PW'(DEPTH);
  localparam logic [DATABUF_HIGH_NUM-1:0] CNT_MAX = '1;

  pkt_state_e                  state;
  logic [PW-1:0]               rd_ptr, commit_ptr, wr_ptr;
  logic [AW-1:0]               hdr_ptr;
  logic [DATABUF_HIGH_NUM-1:0] cnt;
  logic [CRC32_LENGTH-1:0]     crc;
  logic [PRI_W-1:0]            pri;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]           used_c, used_w;
  logic                    sop_room, word_room;
  logic [CRC32_LENGTH-1:0] crc_sop, crc_word;
  logic                    dat_we, hdr_we;
  logic [AW-1:0]           dat_addr, hdr_addr;
  logic [DATA_WIDTH-1:0]   hdr_word;

  // Occupancy is measured against rd_ptr before any same-cycle read
  assign used_c    = commit_ptr - rd_ptr;
  assign used_w    = wr_ptr - rd_ptr;
  assign sop_room  = used_c <= (FULL_USED - PW'(2));
  assign word_room = (used_w != FULL_USED) && (cnt != CNT_MAX);
  assign crc_sop   = crc32_next(CRC32_INIT, wr_data);
  assign crc_word  = crc32_next(crc, wr_data);

  assign empty   = (rd_ptr == commit_ptr);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_comb begin
    dat_we   = 1'b0;
    dat_addr = wr_ptr[AW-1:0];
    hdr_we   = 1'b0;
    hdr_addr = hdr_ptr;
    hdr_word = make_header(cnt + DATABUF_HIGH_NUM'(1), crc_word, pri);
    if (wr_vld) begin
      if (wr_sop) begin
        if (sop_room) begin
          dat_we   = 1'b1;
          dat_addr = commit_ptr[AW-1:0] + AW'(1);
          if (wr_eop) begin
            hdr_we   = 1'b1;
            hdr_addr = commit_ptr[AW-1:0];
            hdr_word = make_header(DATABUF_HIGH_NUM'(1), crc_sop, wr_pri);
          end
        end
      end else if (state == PKT_FILL && word_room) begin
        dat_we = 1'b1;
        hdr_we = wr_eop;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (dat_we) mem[dat_addr] <= wr_data;
    if (hdr_we) mem[hdr_addr] <= hdr_word;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= PKT_IDLE;
      rd_ptr     <= '0;
      commit_ptr <= '0;
      wr_ptr     <= '0;
      hdr_ptr    <= '0;
      cnt        <= '0;
      crc        <= CRC32_INIT;
      pri        <= '0;
      drop       <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (rd_en && !empty) rd_ptr <= rd_ptr + PW'(1);
      if (wr_vld) begin
        if (wr_sop) begin
          // A sop while filling abandons the old packet; the new one still starts
          if (sop_room) begin
            drop    <= (state == PKT_FILL);
            hdr_ptr <= commit_ptr[AW-1:0];
            pri     <= wr_pri;
            cnt     <= DATABUF_HIGH_NUM'(1);
            crc     <= crc_sop;
            wr_ptr  <= commit_ptr + PW'(2);
            if (wr_eop) begin
              commit_ptr <= commit_ptr + PW'(2);
              state      <= PKT_IDLE;
            end else begin
              state <= PKT_FILL;
            end
          end else begin
            wr_ptr <= commit_ptr;
            drop   <= 1'b1;
            state  <= PKT_DISCARD;
          end
        end else if (state == PKT_FILL) begin
          if (word_room) begin
            wr_ptr <= wr_ptr + PW'(1);
            cnt    <= cnt + DATABUF_HIGH_NUM'(1);
            crc    <= crc_word;
            if (wr_eop) begin
              commit_ptr <= wr_ptr + PW'(1);
              state      <= PKT_IDLE;
            end
          end else begin
            wr_ptr <= commit_ptr;
            drop   <= 1'b1;
            state  <= PKT_DISCARD;
          end
        end else if (state == PKT_DISCARD && wr_eop) begin
          state <= PKT_IDLE;
        end
      end
    end
  end
endmodule

// File: rtl/out_queue_bank.sv
// Bank of per-port packet queues with a shared registered read port.
// Optional per-port drop counters under `OUT_QUEUE_DROP_CNT_EN.
module out_queue_bank
  import out_queue_bank_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PORT_WIDTH-1:0]     wr_port,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      wr_vld,
  input  logic                      wr_sop,
  input  logic                      wr_eop,
  input  logic [PRI_W-1:0]          wr_pri,
  input  logic [PORT_WIDTH-1:0]     rd_sel,
  input  logic                      rd_en,
`ifdef OUT_QUEUE_DROP_CNT_EN
  input  logic [PORT_WIDTH-1:0]     cnt_sel,
  input  logic                      cnt_clr,
  output logic [15:0]               drop_cnt,
`endif
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic [PORT_NUB_TOTAL-1:0] empty,
  output logic [PORT_NUB_TOTAL-1:0] drop,
  output logic                      rd_err
);
  localparam int QUEUE_DEPTH = 64;

  logic [PORT_NUB_TOTAL-1:0][DATA_WIDTH-1:0] rd_word;

  for (genvar p = 0; p < PORT_NUB_TOTAL; p++) begin : g_port
    port_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_vld  (wr_vld && (wr_port == PORT_WIDTH'(p))),
      .wr_sop  (wr_sop),
      .wr_eop  (wr_eop),
      .wr_data (wr_data),
      .wr_pri  (wr_pri),
      .rd_en   (rd_en && (rd_sel == PORT_WIDTH'(p))),
      .rd_data (rd_word[p]),
      .empty   (empty[p]),
      .drop    (drop[p])
    );
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      data_out <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_err <= rd_en && empty[rd_sel];
      if (rd_en && !empty[rd_sel]) data_out <= rd_word[rd_sel];
    end
  end

`ifdef OUT_QUEUE_DROP_CNT_EN
  logic [PORT_NUB_TOTAL-1:0][15:0] drop_ctr;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      drop_ctr <= '0;
      drop_cnt <= '0;
    end else begin
      for (int p = 0; p < PORT_NUB_TOTAL; p++) begin
        if (cnt_clr && cnt_sel == PORT_WIDTH'(p)) drop_ctr[p] <= '0;
        else if (drop[p] && drop_ctr[p] != 16'hFFFF) drop_ctr[p] <= drop_ctr[p] + 16'd1;
      end
      drop_cnt <= drop_ctr[cnt_sel];
    end
  end
`endif
endmodule

// File: doc/out_queue_bank.md
OUT_QUEUE_BANK -- requirements
Module: out_queue_bank

Interface
REQ-001 Parameters and constants come from generate_parameter.vh: DATA_WIDTH, PORT_NUB_TOTAL, PRI_NUM_TOTAL, CRC32_LENGTH (32), DATABUF_HIGH_NUM.
REQ-002 Local parameter QUEUE_DEPTH, default 64, gives the words per port queue; it SHALL be a power of 2.
REQ-003 Derived widths: PORT_WIDTH = clog2(PORT_NUB_TOTAL), PRI_W = clog2(PRI_NUM_TOTAL).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-high reset (the port name follows codebase naming; asserted = 1).
REQ-006 wr_port  in  PORT_WIDTH  destination queue of the current write word.
REQ-007 wr_data  in  DATA_WIDTH  payload word.
REQ-008 wr_vld / wr_sop / wr_eop  in  1 each  word valid, first word of packet, last word of packet.
REQ-009 wr_pri  in  PRI_W  packet priority, sampled with wr_sop.
REQ-010 rd_sel  in  PORT_WIDTH  read queue select (driven by sel_control).
REQ-011 rd_en  in  1  read request.
REQ-012 data_out  out  DATA_WIDTH  read word, registered.
REQ-013 empty  out  PORT_NUB_TOTAL  per-port queue holds no committed word.
REQ-014 drop  out  PORT_NUB_TOTAL  one-cycle pulse per dropped packet.
REQ-015 rd_err  out  1  one-cycle pulse on rd_en to an empty queue.

Function
REQ-016 Each port queue SHALL be a circular buffer with rd_ptr, commit_ptr and wr_ptr, each clog2(QUEUE_DEPTH)+1 bits wide with a wrap bit.
REQ-017 On wr_vld&wr_sop, the block SHALL reserve the slot at wr_ptr for a header, write wr_data to the next slot, latch wr_pri, and set that port's word count to 1 and its CRC to 0xFFFFFFFF before updating it with the word.
REQ-018 Each subsequent wr_vld word SHALL be stored, increment the word count, and update the CRC: polynomial 0x04C11DB7, MSB first, no reflection, no final XOR.
REQ-019 On wr_eop, in the same cycle as the last data write, the header SHALL be written at the reserved slot as {zero pad, frame_num[DATABUF_HIGH_NUM], crc[32], pri[PRI_W]}, LSB-aligned; commit_ptr <= new wr_ptr.
REQ-020 wr_sop&wr_eop together is a single-word packet: header and one data word are committed in that cycle.
REQ-021 empty[p] = (rd_ptr == commit_ptr); it SHALL deassert the cycle after commit.
REQ-022 Uncommitted words SHALL never be readable.
REQ-023 Read: on rd_en with empty[rd_sel]=0, data_out <= mem[rd_sel][rd_ptr] and rd_ptr increments; the word is valid the cycle after rd_en.
REQ-024 On rd_en with empty[rd_sel]=1, data_out SHALL hold its value, no pointer SHALL move, and rd_err SHALL pulse.
REQ-025 Drop cases: fewer than 2 free slots at sop; queue full on a later word; word count would exceed 2^DATABUF_HIGH_NUM-1; a new sop before eop on the same port.
REQ-026 On a drop, wr_ptr SHALL rewind to commit_ptr and drop[p] SHALL pulse. Further words up to the next sop are discarded, except in the sop-before-eop case, where the new packet starts normally.
REQ-027 A word with wr_vld and no packet in progress on that port SHALL be discarded silently.
REQ-028 A read and a write on the same port in the same cycle SHALL both take effect; free space is computed from rd_ptr before the read.
REQ-029 Per-port packet state is one of IDLE, FILL, DISCARD: sop moves to FILL; eop moves to IDLE; a drop moves to DISCARD; sop moves DISCARD to FILL.

Reset
REQ-030 While rst_n=1: all pointers 0, all states IDLE, empty all-ones, data_out 0, drop 0, rd_err 0; memory contents are not reset.
REQ-031 Reset mid-packet SHALL discard all queued and in-flight data.

Configuration
REQ-032 With `OUT_QUEUE_DROP_CNT_EN defined, the block SHALL add per-port 16-bit saturating drop counters, inputs cnt_sel[PORT_WIDTH] and cnt_clr[1], and output drop_cnt[16] as a registered read of counter cnt_sel; cnt_clr zeroes that counter. Without the macro, none of these ports or counters SHALL exist.

Structure
REQ-033 The CRC-32 next-state function, the header field offsets and the IDLE/FILL/DISCARD encodings SHALL reside in a shared package/include next to generate_parameter.vh.
REQ-034 One sub-module, port_queue (single circular buffer with a header-write port, commit and rewind), SHALL be instantiated PORT_NUB_TOTAL times.

Verification
REQ-035 4-word packet, port 2, wr_pri=3 -> empty[2] falls 1 cycle after eop; 5 reads return header frame_num=4, pri=3, crc=golden, then 4 data words.
REQ-036 Single-word packet with sop=eop=1 -> header frame_num=1 plus 1 data word; empty drops next cycle.
REQ-037 QUEUE_DEPTH=64, 70-word packet -> drop pulses at word 64, empty stays 1, the next sop packet commits correctly.
REQ-038 rd_en to an empty port 0 -> rd_err=1 for 1 cycle, data_out unchanged.
REQ-039 Interleaved packets to ports 0 and 1 with simultaneous reads of port 0 -> each header CRC matches its own stream; no cross-contamination.
REQ-040 rst_n pulse mid-packet on port 3 -> empty=all-ones; a subsequent 2-word packet reads back frame_num=2.
